regfile_wr_queue: RTL

REGFILE_WR_QUEUE -- requirements
Module: regfile_wr_queue

---
 rtl/regfile_wr_queue.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_wr_queue.sv
// Write queue that buffers {addr, data} requests and drains one per un-held cycle into a register file (optional lookup: WRQ_LOOKUP_EN).
// Latency: an entry pushed at edge k drives load/Din in cycle k..k+1 when the queue was empty and hold is low.
// Backpressure: wr_ready drops while full (even if a pop happens that cycle); hold stalls the drain; flush discards everything.
module regfile_wr_queue #(
    parameter int DEPTH = 4,
    parameter int NREG  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [2:0]               wr_addr,
    input  logic [15:0]              wr_data,
    input  logic                     hold,
    input  logic                     flush,
    output logic [NREG-1:0]          load,
    output logic [15:0]              Din,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    input  logic [2:0]               chk_addr,
    output logic                     chk_hit,
    output logic [15:0]              chk_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [NREG-1:0] LOAD_ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic [2:0]    mem_addr [DEPTH];
    logic [15:0]   mem_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full;
    // flush wins over both push and pop
    assign push     = wr_valid && wr_ready && !flush;
    assign pop      = !empty && !hold && !flush;

    // Pointer and occupancy state; reset and flush both leave the queue empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Entry storage is only written on a push; its contents are meaningless outside [head, tail)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[tail] <= wr_addr;
            mem_data[tail] <= wr_data;
        end
    end

    // Head entry drives the register file; load is suppressed while held or flushing
    always_comb begin
        load = '0;
        Din  = '0;
        if (!empty) begin
            Din = mem_data[head];
            if (!hold && !flush) load = LOAD_ONE << mem_addr[head];
        end
    end

`ifdef WRQ_LOOKUP_EN
    logic [PW-1:0] lk_idx;

    // Scan oldest to newest so the newest matching pending entry wins
    always_comb begin
        chk_hit  = 1'b0;
        chk_data = '0;
        lk_idx   = head;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head + PW'(i);
            if ((CW'(i) < count) && (mem_addr[lk_idx] == chk_addr)) begin
                chk_hit  = 1'b1;
                chk_data = mem_data[lk_idx];
            end
        end
    end
`else
    logic unused_chk_addr;
    assign unused_chk_addr = ^chk_addr;
    assign chk_hit  = 1'b0;
    assign chk_data = '0;
`endif

endmodule
